// File: rtl/evt_frame_arbiter_if.sv
// rtl/evt_frame_arbiter_if.sv - event dispatcher inputs, DMA output slice and status pulses
interface evt_frame_arbiter_if #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
);
  logic [NUM_CH-1:0]    ch_en_in;
  logic [NUM_CH*32-1:0] evt_data_in;
  logic [NUM_CH*4-1:0]  evt_keep_in;
  logic [NUM_CH-1:0]    evt_last_in;
  logic [NUM_CH-1:0]    evt_vld_in;
  logic [NUM_CH-1:0]    evt_rdy_out;
  logic [31:0]          evt_data_out;
  logic [3:0]           evt_keep_out;
  logic                 evt_last_out;
  logic [CH_BITS-1:0]   evt_dest_out;
  logic                 evt_vld_out;
  logic                 evt_rdy_in;
  logic [NUM_CH-1:0]    frm_done_out;
  logic [NUM_CH-1:0]    drp_cnt_out;

  modport slave (
    input  ch_en_in, evt_data_in, evt_keep_in, evt_last_in, evt_vld_in, evt_rdy_in,
    output evt_rdy_out, evt_data_out, evt_keep_out, evt_last_out, evt_dest_out,
           evt_vld_out, frm_done_out, drp_cnt_out
  );

  modport master (
    output ch_en_in, evt_data_in, evt_keep_in, evt_last_in, evt_vld_in, evt_rdy_in,
    input  evt_rdy_out, evt_data_out, evt_keep_out, evt_last_out, evt_dest_out,
           evt_vld_out, frm_done_out, drp_cnt_out
  );
endinterface

// File: rtl/evt_frame_arbiter.sv
// rtl/evt_frame_arbiter.sv - frame-granular round-robin arbiter of NUM_CH event streams onto one registered slice
module evt_frame_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  evt_frame_arbiter_if.slave   bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [CH_BITS-1:0]   grant, last_grant, pick;
  logic [CH_BITS:0]     scan;
  logic                 found;
  logic [NUM_CH-1:0]    req, rdy, drop, grant_oh;
  logic                 slot_free, accept, accept_last;
  logic [31:0]          sel_data;
  logic [3:0]           sel_keep;
  logic                 sel_last, sel_vld;

  logic [31:0]          data_q;
  logic [3:0]           keep_q;
  logic                 last_q, vld_q;
  logic [CH_BITS-1:0]   dest_q;
  logic [NUM_CH-1:0]    done_q, drp_q;

  // Rotating priority: first requester strictly after the last channel that finished a frame.
  always_comb begin
    req   = bus.evt_vld_in & bus.ch_en_in;
    pick  = '0;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = {1'b0, last_grant} + (CH_BITS+1)'(i + 1);
      if (scan >= (CH_BITS+1)'(NUM_CH)) scan = scan - (CH_BITS+1)'(NUM_CH);
      if (!found && req[scan[CH_BITS-1:0]]) begin
        found = 1'b1;
        pick  = scan[CH_BITS-1:0];
      end
    end
  end

  always_comb begin
    slot_free = !vld_q || bus.evt_rdy_in;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_vld   = 1'b0;
    grant_oh  = '0;
    rdy       = '0;
    drop      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == CH_BITS'(c)) begin
        sel_data    = bus.evt_data_in[32*c +: 32];
        sel_keep    = bus.evt_keep_in[4*c +: 4];
        sel_last    = bus.evt_last_in[c];
        sel_vld     = bus.evt_vld_in[c];
        grant_oh[c] = 1'b1;
      end
      // The owning channel keeps its frame even if its enable drops mid-frame.
      if (state == BUSY && grant == CH_BITS'(c)) begin
        rdy[c] = slot_free;
      end else if (!bus.ch_en_in[c]) begin
        rdy[c]  = 1'b1;
        drop[c] = bus.evt_vld_in[c];
      end
    end
    accept      = (state == BUSY) && sel_vld && slot_free;
    accept_last = accept && sel_last;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= CH_BITS'(NUM_CH - 1);
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      dest_q     <= '0;
      done_q     <= '0;
      drp_q      <= '0;
    end else begin
      if (state == IDLE && found) grant <= pick;
      if (accept_last) last_grant <= grant;
      done_q <= accept_last ? grant_oh : '0;
      drp_q  <= drop;
      if (accept) begin
        vld_q  <= 1'b1;
        last_q <= sel_last;
        dest_q <= grant;
      end else if (slot_free) begin
        vld_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= sel_data;
      keep_q <= sel_keep;
    end
  end

  assign bus.evt_rdy_out  = rdy;
  assign bus.evt_data_out = data_q;
  assign bus.evt_keep_out = keep_q;
  assign bus.evt_last_out = last_q;
  assign bus.evt_dest_out = dest_q;
  assign bus.evt_vld_out  = vld_q;
  assign bus.frm_done_out = done_q;
  assign bus.drp_cnt_out  = drp_q;
endmodule
